// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_pkg
// Description : Shared constants and types for the dual-port RAM slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_pkg;

  localparam int DPRAM_DATA_W = 128;
  localparam int DPRAM_ADDR_W = 3;

  typedef logic [DPRAM_DATA_W-1:0] dpram_word_t;
  typedef logic [DPRAM_ADDR_W-1:0] dpram_addr_t;

endpackage : dpram_pkg
`default_nettype wire

// File: rtl/dualport_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : dualport_ram_if
// Description : Two-client bus bundle for the dual-port RAM. The master
//               drives addresses, write enables and write data; the slave
//               (the RAM) returns the registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface dualport_ram_if
  import dpram_pkg::*;
#(
  parameter int DATA_W = DPRAM_DATA_W,
  parameter int ADDR_W = DPRAM_ADDR_W
);

  logic [DATA_W-1:0] data_in_a;
  logic              wr_en_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_in_b;
  logic              wr_en_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_out_a;
  logic [DATA_W-1:0] data_out_b;

  modport master (
    output data_in_a, wr_en_a, addr_a,
    output data_in_b, wr_en_b, addr_b,
    input  data_out_a, data_out_b
  );

  modport slave (
    input  data_in_a, wr_en_a, addr_a,
    input  data_in_b, wr_en_b, addr_b,
    output data_out_a, data_out_b
  );

endinterface : dualport_ram_if
`default_nettype wire

// File: rtl/dpram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dpram_wr_arbiter
// Description : Combinational write resolution for the dual-port RAM.
//               Computes each entry's next value (port B beats port A on a
//               same-address collision) and the write-first read data for
//               both ports, which covers write-through and cross-port
//               forwarding in one place.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_wr_arbiter
  import dpram_pkg::*;
#(
  parameter int DATA_W = DPRAM_DATA_W,
  parameter int ADDR_W = DPRAM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  wire logic [DEPTH-1:0][DATA_W-1:0] i_mem,
  input  wire logic                         i_wr_en_a,
  input  wire logic [ADDR_W-1:0]            i_addr_a,
  input  wire logic [DATA_W-1:0]            i_data_a,
  input  wire logic                         i_wr_en_b,
  input  wire logic [ADDR_W-1:0]            i_addr_b,
  input  wire logic [DATA_W-1:0]            i_data_b,
  output logic      [DEPTH-1:0][DATA_W-1:0] o_mem_next,
  output logic      [DATA_W-1:0]            o_rd_a,
  output logic      [DATA_W-1:0]            o_rd_b
);

  logic [DEPTH-1:0][DATA_W-1:0] w_mem_next;

  // Per-entry next value: B is tested first so it wins a collision.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic w_hit_a;
    logic w_hit_b;
    assign w_hit_a = i_wr_en_a && (i_addr_a == ADDR_W'(gi));
    assign w_hit_b = i_wr_en_b && (i_addr_b == ADDR_W'(gi));
    assign w_mem_next[gi] = w_hit_b ? i_data_b :
                            w_hit_a ? i_data_a :
                                      i_mem[gi];
  end

  // Reads see this cycle's writes already applied (write-first).
  assign o_mem_next = w_mem_next;
  assign o_rd_a     = w_mem_next[i_addr_a];
  assign o_rd_b     = w_mem_next[i_addr_b];

endmodule : dpram_wr_arbiter
`default_nettype wire

// File: rtl/dualport_ram.sv
`default_nettype none
// ============================================================================
// Module      : dualport_ram
// Description : True dual-port synchronous RAM built from flops, with
//               registered read outputs. Holds the storage array and the
//               output registers; write arbitration lives in the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module dualport_ram
  import dpram_pkg::*;
#(
  parameter int DATA_W = DPRAM_DATA_W,
  parameter int ADDR_W = DPRAM_ADDR_W
) (
  input  wire logic        clk,
  input  wire logic        rst,
  dualport_ram_if.slave    bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DATA_W-1:0]            r_dout_a;
  logic [DATA_W-1:0]            r_dout_b;
  logic [DEPTH-1:0][DATA_W-1:0] w_mem_next;
  logic [DATA_W-1:0]            w_rd_a;
  logic [DATA_W-1:0]            w_rd_b;

  dpram_wr_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_arb (
    .i_mem      (r_mem),
    .i_wr_en_a  (bus.wr_en_a),
    .i_addr_a   (bus.addr_a),
    .i_data_a   (bus.data_in_a),
    .i_wr_en_b  (bus.wr_en_b),
    .i_addr_b   (bus.addr_b),
    .i_data_b   (bus.data_in_b),
    .o_mem_next (w_mem_next),
    .o_rd_a     (w_rd_a),
    .o_rd_b     (w_rd_b)
  );

  // Storage and read registers; reset clears everything and drops writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem    <= '0;
      r_dout_a <= '0;
      r_dout_b <= '0;
    end else begin
      r_mem    <= w_mem_next;
      r_dout_a <= w_rd_a;
      r_dout_b <= w_rd_b;
    end
  end

  assign bus.data_out_a = r_dout_a;
  assign bus.data_out_b = r_dout_b;

endmodule : dualport_ram
`default_nettype wire

// File: tb/tb_dualport_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_dualport_ram
// Description : Self-checking bench for dualport_ram. Each driven cycle
//               pushes the predicted outputs onto per-port queues; they are
//               popped and compared once the registered outputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dualport_ram;
  import dpram_pkg::*;

  logic clk;
  logic rst;

  dualport_ram_if #(.DATA_W(DPRAM_DATA_W), .ADDR_W(DPRAM_ADDR_W)) dif ();

  dualport_ram #(.DATA_W(DPRAM_DATA_W), .ADDR_W(DPRAM_ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  dpram_word_t m [8];
  dpram_word_t q_a [$];
  dpram_word_t q_b [$];
  dpram_word_t ea;
  dpram_word_t eb;

  // Drive one cycle, predict its outputs, wait until they are registered.
  task automatic drive(input logic r,
                       input logic wa, input logic [2:0] aa, input dpram_word_t da,
                       input logic wb, input logic [2:0] ab, input dpram_word_t db);
    dpram_word_t pa, pb;
    rst = r;
    dif.wr_en_a = wa; dif.addr_a = aa; dif.data_in_a = da;
    dif.wr_en_b = wb; dif.addr_b = ab; dif.data_in_b = db;
    if (r) begin
      for (int i = 0; i < 8; i++) m[i] = '0;
      pa = '0; pb = '0;
    end else begin
      if (wa) m[aa] = da;
      if (wb) m[ab] = db;
      pa = m[aa]; pb = m[ab];
    end
    q_a.push_back(pa);
    q_b.push_back(pb);
    @(posedge clk);
    #1;
  endtask

  function automatic dpram_word_t rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    drive(1'b1, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL reset_init_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL reset_init_b got=%h exp=%h", dif.data_out_b, eb); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), rand_word(), 1'b0, 3'(7 - i), '0);
      ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
      if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL fill_a[%0d] got=%h exp=%h", i, dif.data_out_a, ea); end
      if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL fill_b[%0d] got=%h exp=%h", i, dif.data_out_b, eb); end
    end
    drive(1'b1, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL reset_out_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL reset_out_b got=%h exp=%h", dif.data_out_b, eb); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'(i), '0, 1'b0, 3'(i), '0);
      ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
      if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL reset_rd_a[%0d] got=%h exp=%h", i, dif.data_out_a, ea); end
      if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL reset_rd_b[%0d] got=%h exp=%h", i, dif.data_out_b, eb); end
    end
  endtask

  task automatic test_independent();
    drive(1'b0, 1'b1, 3'd1, 128'hA5A5, 1'b1, 3'd6, 128'h1234);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL indep_wr_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL indep_wr_b got=%h exp=%h", dif.data_out_b, eb); end
    drive(1'b0, 1'b0, 3'd6, '0, 1'b0, 3'd1, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL indep_rd_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL indep_rd_b got=%h exp=%h", dif.data_out_b, eb); end
  endtask

  task automatic test_collision();
    drive(1'b0, 1'b1, 3'd3, 128'h1111, 1'b1, 3'd3, 128'h2222);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL collide_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL collide_b got=%h exp=%h", dif.data_out_b, eb); end
    drive(1'b0, 1'b0, 3'd3, '0, 1'b0, 3'd3, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL collide_rd_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL collide_rd_b got=%h exp=%h", dif.data_out_b, eb); end
  endtask

  task automatic test_forward();
    drive(1'b0, 1'b1, 3'd5, 128'hDEAD, 1'b0, 3'd5, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL fwd_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL fwd_b_from_a got=%h exp=%h", dif.data_out_b, eb); end
    drive(1'b0, 1'b0, 3'd5, '0, 1'b1, 3'd5, 128'hBEE5);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL fwd_a_from_b got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL fwd_b got=%h exp=%h", dif.data_out_b, eb); end
  endtask

  task automatic test_latency();
    drive(1'b0, 1'b1, 3'd2, 128'hBEEF, 1'b0, 3'd0, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 1;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL lat_wr_a got=%h exp=%h", dif.data_out_a, ea); end
    drive(1'b0, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 1;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL lat_rd0_a got=%h exp=%h", dif.data_out_a, ea); end
    // Apply the new read address mid-cycle: output must not move before the edge.
    dif.addr_a = 3'd2;
    #2;
    n_cmp += 1;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL lat_hold_a got=%h exp=%h", dif.data_out_a, ea); end
    drive(1'b0, 1'b0, 3'd2, '0, 1'b0, 3'd2, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL lat_rd2_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL lat_rd2_b got=%h exp=%h", dif.data_out_b, eb); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 3'd4, 128'hFFFF, 1'b1, 3'd2, 128'h7777);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL rstmid_a got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL rstmid_b got=%h exp=%h", dif.data_out_b, eb); end
    drive(1'b0, 1'b0, 3'd4, '0, 1'b0, 3'd2, '0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
    if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL rstmid_rd4 got=%h exp=%h", dif.data_out_a, ea); end
    if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL rstmid_rd2 got=%h exp=%h", dif.data_out_b, eb); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, 1'($urandom), 3'($urandom), rand_word(),
                  1'($urandom), 3'($urandom), rand_word());
      ea = q_a.pop_front(); eb = q_b.pop_front(); n_cmp += 2;
      if (dif.data_out_a !== ea) begin n_bad++; $display("FAIL b2b_a[%0d] got=%h exp=%h", i, dif.data_out_a, ea); end
      if (dif.data_out_b !== eb) begin n_bad++; $display("FAIL b2b_b[%0d] got=%h exp=%h", i, dif.data_out_b, eb); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    dif.wr_en_a = 1'b0; dif.addr_a = '0; dif.data_in_a = '0;
    dif.wr_en_b = 1'b0; dif.addr_b = '0; dif.data_in_b = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_independent();
    test_collision();
    test_forward();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dualport_ram
`default_nettype wire

// File: doc/dualport_ram.md
Name: dualport_ram

Overview:
True dual-port synchronous RAM, 8 words x 128 bits by default. Ports A and B can each independently read or write any address every cycle. Register-based storage with registered read outputs, used as a small shared buffer between two clients in the same clock domain. If both ports write the same address in one cycle, port B wins.

Parameters:
DATA_W, 128, word width in bits.
ADDR_W, 3, address width in bits.
DEPTH, 2**ADDR_W (8), number of words. Derived; not overridden independently.

Ports:
clk  input  1  single clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
data_in_a  input  DATA_W  port A write data.
wr_en_a  input  1  port A write enable; 1 = write, 0 = read.
addr_a  input  ADDR_W  port A address.
data_in_b  input  DATA_W  port B write data.
wr_en_b  input  1  port B write enable; 1 = write, 0 = read.
addr_b  input  ADDR_W  port B address.
data_out_a  output  DATA_W  port A registered read data.
data_out_b  output  DATA_W  port B registered read data.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: when rst=1 at a rising edge, all DEPTH words clear to 0 and data_out_a/data_out_b clear to 0. Writes are ignored in that cycle. Reset has priority over all other activity.
- Write: if wr_en_x=1 at a rising edge, mem[addr_x] <= data_in_x. The new value is visible to a read at the next edge.
- Read: data_out_x is registered with 1-cycle latency. At each edge, data_out_x <= content of mem[addr_x] after this edge's writes are applied (write-first).
- Same-port write: data_out_x shows the data just written (write-through) in the following cycle.
- Same-address collision, both ports writing: port B wins. mem[addr] <= data_in_b, and both data_out_a and data_out_b show data_in_b.
- Cross-port read-during-write: port X reads address N while port Y writes N. data_out_X shows Y's new data (forwarding).
- Both ports reading the same address: both outputs return the identical stored word.
- Different addresses: the ports operate fully independently.
- Outputs hold their value only until the next edge; they update every cycle. There is no output enable.
- Addresses always fall in range (DEPTH = 2**ADDR_W), so no bounds check is needed.
- Storage is flops (array of DATA_W registers). There are no uninitialised (X) words after reset.

Decomposition:
- Shared package dpram_pkg holds the default constants DPRAM_DATA_W=128 and DPRAM_ADDR_W=3, plus the typedefs dpram_word_t (logic [DATA_W-1:0]) and dpram_addr_t.
- One sub-module is natural: dpram_wr_arbiter. It resolves the per-entry next value from the two write requests with B priority, and generates the forwarded read values.
- The top level holds the storage array and the output registers.

Test Plan:
- Reset: after writes, assert rst for 1 cycle, then read addr 0..7 on both ports -> all outputs 128'h0.
- Independent writes: A writes addr 1 = 128'hA5A5, B writes addr 6 = 128'h1234 in the same cycle. Next cycle, read A@6 and B@1 -> data_out_a=128'h1234, data_out_b=128'hA5A5.
- Collision: both write addr 3 (A=128'h1111, B=128'h2222) -> both outputs 128'h2222 next cycle. A later read of addr 3 -> 128'h2222.
- Cross-port forwarding: A writes addr 5 = 128'hDEAD while B reads addr 5 -> data_out_b=128'hDEAD one cycle later.
- Latency: write addr 2 = 128'hBEEF, then read addr 2 -> data_out changes exactly one edge after the read address is applied.
- Reset mid-operation: rst=1 with wr_en_a=1, addr 4 = 128'hFFFF -> mem[4] stays 0 and outputs are 0 the next cycle.
